// File: rtl/mul_req_ctrl.sv
// Request controller: FIFO-buffers operand pairs, drives a start/done multiplier and returns
// products on a valid/ready port. Define MUL_REQ_CTRL_TIMEOUT_EN to enable the WAIT timeout.

module mul_req_ctrl #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_a,
  input  logic [DATA_W-1:0]   in_b,
  output logic [DATA_W-1:0]   mul_a,
  output logic [DATA_W-1:0]   mul_b,
  output logic                mul_start,
  input  logic                mul_done,
  input  logic [2*DATA_W-1:0] mul_result,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*DATA_W-1:0] out_result,
  output logic                out_err,
  output logic                busy
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gen_bad_depth
    $error("FIFO_DEPTH must be a power of 2 and at least 2");
  end
  if (TIMEOUT_CYC < 1) begin : gen_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StHold} state_e;

  state_e state_q, state_d;

  logic [DATA_W-1:0]   fifo_a_q [FIFO_DEPTH];
  logic [DATA_W-1:0]   fifo_b_q [FIFO_DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]     count_q, count_d;
  logic                full, empty, push, pop;
  logic                capture, timeout;
  logic [DATA_W-1:0]   mul_a_q, mul_b_q;
  logic [2*DATA_W-1:0] out_result_q;

  assign full     = (count_q == CntW'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  // No bypass: a pop in the same cycle does not reopen a full FIFO.
  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign count_d  = count_q + CntW'(push) - CntW'(pop);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_a_q[wr_ptr_q] <= in_a;
      fifo_b_q[wr_ptr_q] <= in_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = StIssue;
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        if (mul_done || timeout) begin
          capture = 1'b1;
          state_d = StHold;
        end
      end
      StHold: begin
        if (out_ready) begin
          if (!empty) begin
            pop     = 1'b1;
            state_d = StIssue;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      out_result_q <= '0;
    end else begin
      state_q <= state_d;
      if (pop) begin
        mul_a_q <= fifo_a_q[rd_ptr_q];
        mul_b_q <= fifo_b_q[rd_ptr_q];
      end
      // Done wins over a simultaneous timeout; an aborted request returns zero.
      if (capture) out_result_q <= mul_done ? mul_result : '0;
    end
  end

`ifdef MUL_REQ_CTRL_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);

  logic [TmoW-1:0] wait_cnt_q;
  logic            out_err_q;

  assign timeout = (state_q == StWait) && (wait_cnt_q == TmoW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
      out_err_q  <= 1'b0;
    end else begin
      if (state_q == StWait) wait_cnt_q <= wait_cnt_q + TmoW'(1);
      else                   wait_cnt_q <= '0;
      if (capture) out_err_q <= !mul_done;
    end
  end

  assign out_err = out_err_q;
`else
  assign timeout = 1'b0;
  assign out_err = 1'b0;
`endif

  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign mul_start  = (state_q == StIssue);
  assign out_valid  = (state_q == StHold);
  assign out_result = out_result_q;
  assign busy       = (state_q != StIdle) || !empty;

endmodule

// File: tb/tb_mul_req_ctrl.sv
// Self-checking bench for mul_req_ctrl: vector table, directed corner sequences and random
// traffic against a queue-based scoreboard with a 4-cycle multiplier model.
`timescale 1ns/1ps

module tb_mul_req_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_a = '0;
  logic [7:0]  in_b = '0;
  logic [7:0]  mul_a, mul_b;
  logic        mul_start;
  logic        mul_done = 1'b0;
  logic [15:0] mul_result = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_result;
  logic        out_err;
  logic        busy;

  always #5 clk = ~clk;

  mul_req_ctrl #(
    .DATA_W     (8),
    .FIFO_DEPTH (4),
    .TIMEOUT_CYC(16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_start (mul_start),
    .mul_done  (mul_done),
    .mul_result(mul_result),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_err   (out_err),
    .busy      (busy)
  );

  typedef struct { logic [15:0] res; logic err; } exp_t;
  typedef struct { logic [7:0] a; logic [7:0] b; logic [15:0] prod; } vec_t;

  exp_t        exp_q[$];
  exp_t        chk_e;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  bit          auto_en = 1'b1;
  bit          send_done = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    end
  endtask

  task automatic fail_bound(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: no response within cycle budget, expected one", name);
  endtask

  // Multiplier model: start seen in cycle t gives done high in cycle t+4.
  int         cd = 0;
  logic [7:0] pa = '0, pb = '0;
  bit         stab_ok = 1'b0;
  bit         prev_start = 1'b0;

  initial forever begin
    @(negedge clk);
    if (!rst_n) stab_ok = 1'b0;
    mul_done   = 1'b0;
    mul_result = 16'($urandom);
    if (cd > 0) begin
      if (stab_ok) begin
        check("mul_a_stable", 32'(mul_a), 32'(pa));
        check("mul_b_stable", 32'(mul_b), 32'(pb));
      end
      cd--;
      if (cd == 0) begin
        mul_done   = 1'b1;
        mul_result = 16'(pa) * 16'(pb);
      end
    end
    if (mul_start) begin
      check("mul_start_single_pulse", 32'(prev_start), 0);
      if (auto_en) begin
        cd      = 4;
        pa      = mul_a;
        pb      = mul_b;
        stab_ok = 1'b1;
      end
    end
    prev_start = mul_start;
  end

  // Scoreboard: every output handshake must match the oldest accepted request.
  initial forever begin
    @(negedge clk);
    #1;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_output: got result 0x%0h, expected no output", out_result);
      end else begin
        chk_e = exp_q.pop_front();
        check("out_result", 32'(out_result), 32'(chk_e.res));
        check("out_err", 32'(out_err), 32'(chk_e.err));
      end
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [15:0] res,
                      input logic err);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    for (int i = 0; i < 400; i++) begin
      if (in_ready) begin
        exp_q.push_back('{res: res, err: err});
        ok = 1'b1;
      end
      @(negedge clk);
      if (ok) break;
    end
    in_valid = 1'b0;
    if (!ok) fail_bound("send_accept");
  endtask

  task automatic drain(input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) return;
      @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      fail_bound(name);
      exp_q.delete();
    end
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (mul_start) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) fail_bound("wait_start");
  endtask

  task automatic cycles_to_valid(output int n);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_in_ready"},   32'(in_ready),   1);
    check({tag, "_mul_a"},      32'(mul_a),      0);
    check({tag, "_mul_b"},      32'(mul_b),      0);
    check({tag, "_mul_start"},  32'(mul_start),  0);
    check({tag, "_out_valid"},  32'(out_valid),  0);
    check({tag, "_out_result"}, 32'(out_result), 0);
    check({tag, "_out_err"},    32'(out_err),    0);
    check({tag, "_busy"},       32'(busy),       0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[8];
    bit   ok;
    int   n;

    vecs[0] = '{a: 8'd255, b: 8'd255, prod: 16'd65025};
    vecs[1] = '{a: 8'd0,   b: 8'd7,   prod: 16'd0};
    vecs[2] = '{a: 8'd1,   b: 8'd1,   prod: 16'd1};
    vecs[3] = '{a: 8'd16,  b: 8'd16,  prod: 16'd256};
    vecs[4] = '{a: 8'd255, b: 8'd1,   prod: 16'd255};
    vecs[5] = '{a: 8'd128, b: 8'd2,   prod: 16'd256};
    vecs[6] = '{a: 8'd200, b: 8'd100, prod: 16'd20000};
    vecs[7] = '{a: 8'd170, b: 8'd85,  prod: 16'd14450};

    repeat (2) @(negedge clk);
    check_reset("reset");
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Single request: operands held, result valid 5 cycles after start.
    out_ready = 1'b1;
    send(8'd3, 8'd5, 16'd15, 1'b0);
    wait_start(ok);
    check("t1_mul_a", 32'(mul_a), 3);
    check("t1_mul_b", 32'(mul_b), 5);
    cycles_to_valid(n);
    check("t1_latency", 32'(n), 5);
    check("t1_out_result", 32'(out_result), 15);
    drain(50, "t1_drain");

    // Table, one at a time with a direct result check.
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].prod, 1'b0);
      cycles_to_valid(n);
      check("vec_out_result", 32'(out_result), 32'(vecs[i].prod));
      drain(50, "vec_drain");
    end

    // Table again, back-to-back; the scoreboard checks ordering.
    for (int i = 0; i < 8; i++) send(vecs[i].a, vecs[i].b, vecs[i].prod, 1'b0);
    drain(200, "b2b_drain");

    // Back-pressure: result held stable, no second start until the handshake.
    out_ready = 1'b0;
    send(8'd12, 8'd12, 16'd144, 1'b0);
    send(8'd2, 8'd3, 16'd6, 1'b0);
    cycles_to_valid(n);
    for (int i = 0; i < 10; i++) begin
      check("t3_out_valid", 32'(out_valid), 1);
      check("t3_out_result", 32'(out_result), 144);
      check("t3_no_start", 32'(mul_start), 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    drain(100, "t3_drain");

    // Fill: 1 in flight plus 4 queued closes in_ready.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send(8'(i + 1), 8'(20 + i), 16'((i + 1) * (20 + i)), 1'b0);
    end
    check("t4_full_in_ready", 32'(in_ready), 0);
    check("t4_busy", 32'(busy), 1);
    repeat (6) @(negedge clk);
    check("t4_still_full", 32'(in_ready), 0);
    out_ready = 1'b1;
    drain(200, "t4_drain");
    check("t4_idle_busy", 32'(busy), 0);

    // Reset during WAIT; the model's late done must be ignored.
    send(8'd9, 8'd9, 16'd81, 1'b0);
    wait_start(ok);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset("t5");
    exp_q.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("t5_no_out_valid", 32'(out_valid), 0);
    end
    send(8'd4, 8'd4, 16'd16, 1'b0);
    drain(50, "t5_recover");

`ifdef MUL_REQ_CTRL_TIMEOUT_EN
    // No done: abort after 16 WAIT cycles with a zero result and error flag.
    auto_en = 1'b0;
    send(8'd7, 8'd3, 16'd0, 1'b1);
    wait_start(ok);
    cycles_to_valid(n);
    check("t6_timeout_latency", 32'(n), 17);
    check("t6_out_err", 32'(out_err), 1);
    check("t6_out_result", 32'(out_result), 0);
    drain(50, "t6_drain");
    auto_en = 1'b1;
    send(8'd6, 8'd7, 16'd42, 1'b0);
    drain(50, "t6_next");
`endif

    // Random traffic with random back-pressure.
    fork
      begin
        logic [7:0] ra, rb;
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 2)) @(negedge clk);
          ra = 8'($urandom_range(0, 255));
          rb = 8'($urandom_range(0, 255));
          send(ra, rb, 16'(ra) * 16'(rb), 1'b0);
        end
        send_done = 1'b1;
      end
      begin
        for (int c = 0; c < 4000; c++) begin
          @(negedge clk);
          out_ready = ($urandom_range(0, 9) < 7);
          if (send_done && exp_q.size() == 0) break;
        end
      end
    join
    if (exp_q.size() != 0) fail_bound("random_drain");
    out_ready = 1'b1;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
